// File: rtl/control_filtro_pb_pkg.sv
// -----------------------------------------------------------------------------
// control_filtro_pb_pkg
// Shared constants for the second-order filter controller and its datapath:
// state encoding, multiplexer select codes, coefficient codes, enable masks
// and the state-to-control decoder.
// The muxpb5000 datapath uses the same select and coefficient codes.
// -----------------------------------------------------------------------------
package control_filtro_pb_pkg;

  // 4-bit binary state encoding. Each MAC step is an issue/write pair.
  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_S0I   = 4'd1,
    ST_S0W   = 4'd2,
    ST_S1I   = 4'd3,
    ST_S1W   = 4'd4,
    ST_S2I   = 4'd5,
    ST_S2W   = 4'd6,
    ST_S3I   = 4'd7,
    ST_S3W   = 4'd8,
    ST_S4I   = 4'd9,
    ST_S4W   = 4'd10,
    ST_SHIFT = 4'd11,
    ST_FIN   = 4'd12
  } state_e;

  // Multiplicand select (selmuxS)
  localparam logic [2:0] SEL_S_FK  = 3'd0;
  localparam logic [2:0] SEL_S_FK1 = 3'd1;
  localparam logic [2:0] SEL_S_FK2 = 3'd2;

  // Coefficient select (selmuxC); B0 is reused as B2
  localparam logic [1:0] SEL_C_NEG_A1 = 2'd0;
  localparam logic [1:0] SEL_C_NEG_A2 = 2'd1;
  localparam logic [1:0] SEL_C_B0     = 2'd2;
  localparam logic [1:0] SEL_C_B1     = 2'd3;

  // Addend select (selmuxZ)
  localparam logic [2:0] SEL_Z_UK    = 3'd0;
  localparam logic [2:0] SEL_Z_ACUM1 = 3'd1;
  localparam logic [2:0] SEL_Z_ACUM2 = 3'd2;
  localparam logic [2:0] SEL_Z_ACUM3 = 3'd3;
  localparam logic [2:0] SEL_Z_ZERO  = 3'd4;

  // Enable masks, bit 0 = en1 ... bit 6 = en7
  localparam logic [6:0] EN_NONE  = 7'b000_0000;
  localparam logic [6:0] EN_YK    = 7'b000_0001;
  localparam logic [6:0] EN_FK    = 7'b000_0010;
  localparam logic [6:0] EN_FK1   = 7'b000_0100;
  localparam logic [6:0] EN_FK2   = 7'b000_1000;
  localparam logic [6:0] EN_ACUM1 = 7'b001_0000;
  localparam logic [6:0] EN_ACUM2 = 7'b010_0000;
  localparam logic [6:0] EN_ACUM3 = 7'b100_0000;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic [6:0] en;
    logic [2:0] sel_s;
    logic [1:0] sel_c;
    logic [2:0] sel_z;
  } ctl_t;

  // Control word presented while the FSM sits in state s. Selects are shared
  // by both halves of a step; only the W half carries the step's enable.
  function automatic ctl_t decode_ctl(input state_e s);
    ctl_t c;
    c = '0;
    case (s)
      ST_S0I, ST_S0W: begin
        c.sel_s = SEL_S_FK1; c.sel_c = SEL_C_NEG_A1; c.sel_z = SEL_Z_UK;
      end
      ST_S1I, ST_S1W: begin
        c.sel_s = SEL_S_FK2; c.sel_c = SEL_C_NEG_A2; c.sel_z = SEL_Z_ACUM1;
      end
      ST_S2I, ST_S2W: begin
        c.sel_s = SEL_S_FK;  c.sel_c = SEL_C_B0;     c.sel_z = SEL_Z_ZERO;
      end
      ST_S3I, ST_S3W: begin
        c.sel_s = SEL_S_FK1; c.sel_c = SEL_C_B1;     c.sel_z = SEL_Z_ACUM2;
      end
      ST_S4I, ST_S4W: begin
        c.sel_s = SEL_S_FK2; c.sel_c = SEL_C_B0;     c.sel_z = SEL_Z_ACUM3;
      end
      default: begin
        c.sel_s = SEL_S_FK;  c.sel_c = SEL_C_NEG_A1; c.sel_z = SEL_Z_UK;
      end
    endcase
    case (s)
      ST_S0W:   c.en = EN_ACUM1;
      ST_S1W:   c.en = EN_FK;
      ST_S2W:   c.en = EN_ACUM2;
      ST_S3W:   c.en = EN_ACUM3;
      ST_S4W:   c.en = EN_YK;
      // Delay line shifts in one cycle: fk1<-fk and fk2<-old fk1 together
      ST_SHIFT: c.en = EN_FK1 | EN_FK2;
      default:  c.en = EN_NONE;
    endcase
    c.done = (s == ST_FIN);
    c.busy = (s != ST_IDLE);
    return c;
  endfunction

endpackage

// File: rtl/control_filtro_pb.sv
// -----------------------------------------------------------------------------
// control_filtro_pb
// Sequencer for the filtropb5000 second-order filter datapath. On a start
// strobe in IDLE it walks five MAC steps (issue + write each), shifts the
// delay line, then pulses done. All outputs come straight from flops loaded
// with the decode of the next state, so start never reaches an output
// combinationally.
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous, active-low
//   start      new-sample strobe, honoured only in IDLE
//   busy       high from S0I through FIN
//   done       one-cycle pulse in FIN; yk is valid from then on
//   en1..en7   datapath enables: yk, fk, fk1, fk2, acum1, acum2, acum3
//   selmuxS    multiplicand select
//   selmuxC    coefficient select
//   selmuxZ    addend select
// -----------------------------------------------------------------------------
module control_filtro_pb
  import control_filtro_pb_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       en1,
  output logic       en2,
  output logic       en3,
  output logic       en4,
  output logic       en5,
  output logic       en6,
  output logic       en7,
  output logic [2:0] selmuxS,
  output logic [1:0] selmuxC,
  output logic [2:0] selmuxZ
);

  state_e state_q, state_d;
  ctl_t   ctl_q, ctl_d;

  // Next-state logic: only IDLE looks at start, everything else just advances
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  state_d = start ? ST_S0I : ST_IDLE;
      ST_S0I:   state_d = ST_S0W;
      ST_S0W:   state_d = ST_S1I;
      ST_S1I:   state_d = ST_S1W;
      ST_S1W:   state_d = ST_S2I;
      ST_S2I:   state_d = ST_S2W;
      ST_S2W:   state_d = ST_S3I;
      ST_S3I:   state_d = ST_S3W;
      ST_S3W:   state_d = ST_S4I;
      ST_S4I:   state_d = ST_S4W;
      ST_S4W:   state_d = ST_SHIFT;
      ST_SHIFT: state_d = ST_FIN;
      ST_FIN:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output decode of the state being entered, so the flopped outputs line up
  // with state_q
  always_comb begin
    ctl_d = decode_ctl(state_d);
  end

  // State and output registers, cleared asynchronously by reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      ctl_q   <= '0;
    end else begin
      state_q <= state_d;
      ctl_q   <= ctl_d;
    end
  end

  assign busy    = ctl_q.busy;
  assign done    = ctl_q.done;
  assign en1     = ctl_q.en[0];
  assign en2     = ctl_q.en[1];
  assign en3     = ctl_q.en[2];
  assign en4     = ctl_q.en[3];
  assign en5     = ctl_q.en[4];
  assign en6     = ctl_q.en[5];
  assign en7     = ctl_q.en[6];
  assign selmuxS = ctl_q.sel_s;
  assign selmuxC = ctl_q.sel_c;
  assign selmuxZ = ctl_q.sel_z;

endmodule

// File: tb/tb_control_filtro_pb.sv
// -----------------------------------------------------------------------------
// tb_control_filtro_pb
// Scoreboard bench: a reference model turns every accepted start into the
// twelve expected control words of one sample and queues them; a monitor on
// the falling edge pops and compares, expecting all-zero outputs when idle
// or in reset.
// Vector layout: {busy, done, en7..en1, selS[2:0], selC[1:0], selZ[2:0]}
// -----------------------------------------------------------------------------
module tb_control_filtro_pb;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       busy, done;
  logic       en1, en2, en3, en4, en5, en6, en7;
  logic [2:0] selmuxS;
  logic [1:0] selmuxC;
  logic [2:0] selmuxZ;

  control_filtro_pb dut (
    .clk(clk), .reset(reset), .start(start),
    .busy(busy), .done(done),
    .en1(en1), .en2(en2), .en3(en3), .en4(en4),
    .en5(en5), .en6(en6), .en7(en7),
    .selmuxS(selmuxS), .selmuxC(selmuxC), .selmuxZ(selmuxZ)
  );

  always #5 clk = ~clk;

  wire [16:0] dut_vec = {busy, done, en7, en6, en5, en4, en3, en2, en1,
                         selmuxS, selmuxC, selmuxZ};

  logic [16:0] exp_q[$];
  int          cnt_left = 0;
  int          checks   = 0;
  int          errors   = 0;
  int          samples  = 0;

  // Filter steps as written in the algorithm: multiplicand, coefficient,
  // addend, and the enable number (1..7) of the register being written.
  int step_s[5]  = '{1, 2, 0, 1, 2};
  int step_c[5]  = '{0, 1, 2, 3, 2};
  int step_z[5]  = '{0, 1, 4, 2, 3};
  int step_en[5] = '{5, 2, 6, 7, 1};

  function automatic logic [16:0] pack(input bit b, input bit d,
                                       input logic [6:0] en, input logic [2:0] s,
                                       input logic [1:0] c, input logic [2:0] z);
    return {b, d, en, s, c, z};
  endfunction

  task automatic check(input string name, input logic [16:0] act,
                       input logic [16:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Expected response to one accepted sample
  task automatic push_sample();
    logic [6:0] e;
    for (int k = 0; k < 5; k++) begin
      e = 7'd0;
      e[step_en[k]-1] = 1'b1;
      exp_q.push_back(pack(1'b1, 1'b0, 7'd0,
                           3'(step_s[k]), 2'(step_c[k]), 3'(step_z[k])));
      exp_q.push_back(pack(1'b1, 1'b0, e,
                           3'(step_s[k]), 2'(step_c[k]), 3'(step_z[k])));
    end
    exp_q.push_back(pack(1'b1, 1'b0, 7'b000_1100, 3'd0, 2'd0, 3'd0)); // SHIFT
    exp_q.push_back(pack(1'b1, 1'b1, 7'd0, 3'd0, 2'd0, 3'd0));        // FIN
    samples++;
  endtask

  // Reference model: a sample occupies 13 clock edges from acceptance until
  // the controller can take the next start; starts inside that window are lost.
  initial begin
    forever begin
      @(posedge clk);
      if (!reset) begin
        cnt_left = 0;
      end else if (cnt_left == 0) begin
        if (start) begin
          push_sample();
          cnt_left = 12;
        end
      end else begin
        cnt_left--;
      end
    end
  end

  // Monitor
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        exp_q.delete();
        check("in_reset", dut_vec, 17'd0);
      end else if (exp_q.size() > 0) begin
        check("sequence", dut_vec, exp_q.pop_front());
      end else begin
        check("idle", dut_vec, 17'd0);
      end
    end
  end

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // Stimulus
  initial begin
    int guard;
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    #1 reset = 1'b1;

    // Single start right after reset release
    start = 1'b1;
    idle_cycles(1);
    start = 1'b0;
    idle_cycles(15);

    // Second start while busy must be ignored
    start = 1'b1;
    idle_cycles(1);
    start = 1'b0;
    idle_cycles(4);
    start = 1'b1;
    idle_cycles(1);
    start = 1'b0;
    idle_cycles(15);

    // Reset during S3I: outputs clear without waiting for a clock edge
    start = 1'b1;
    idle_cycles(1);
    start = 1'b0;
    repeat (6) @(posedge clk);
    #2 reset = 1'b0;
    #1 check("async_reset", dut_vec, 17'd0);
    idle_cycles(2);
    reset = 1'b1;
    start = 1'b1;
    idle_cycles(1);
    start = 1'b0;
    idle_cycles(15);

    // start held high: back-to-back samples at the minimum period
    start = 1'b1;
    idle_cycles(45);
    start = 1'b0;
    idle_cycles(15);

    // Random start traffic
    repeat (300) begin
      start = ($urandom_range(0, 3) == 0);
      idle_cycles(1);
    end
    start = 1'b0;

    guard = 0;
    while ((exp_q.size() != 0 || cnt_left != 0) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) begin
      errors++;
      checks++;
      $display("FAIL drain_timeout: queue %0d entries left, expected 0", exp_q.size());
    end
    idle_cycles(3);
    if (samples < 5) begin
      errors++;
      $display("FAIL sample_count: got %0d accepted samples, expected at least 5", samples);
    end
    checks++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
